iob_gray_sync_decoder: RTL and testbench

- Receiving end of a gray-coded pointer/counter crossing from another clock domain.
- Synchronizes the gray value through a flop chain, decodes gray to binary, and registers it.
- Flags each legal forward step (+1 mod 2^W) and sets a sticky error on any other change.
- Used on the consumer side of async FIFOs and status counters fed by a gray counter of the same W.

---
 rtl/iob_gray_sync_decoder.sv | 88 ++++++++
 tb/tb_iob_gray_sync_decoder.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/iob_gray_sync_decoder.sv
// Receive side of a gray-coded counter crossing: synchronizes the gray value, decodes it
// to binary, and reports legal +1 steps versus any other change.
`timescale 1ns/1ps

module iob_gray_sync_decoder #(
    parameter int W           = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk_i,
    input  logic         cke_i,
    input  logic         arst_i,
    input  logic         rst_i,
    input  logic         en_i,
    input  logic [W-1:0] gray_i,
    input  logic         err_clr_i,
    output logic [W-1:0] gray_o,
    output logic [W-1:0] data_o,
    output logic         step_o,
    output logic         err_o
);

    logic [SYNC_STAGES-1:0][W-1:0] sync_q, sync_d;
    logic [W-1:0]                  data_q, data_d;
    logic                          step_q, step_d;
    logic                          err_q, err_d;

    logic [W-1:0] bin;
    logic         chg;
    logic         inc;

    function automatic logic [W-1:0] gray2bin(input logic [W-1:0] g);
        logic [W-1:0] b;
        b[W-1] = g[W-1];
        for (int i = W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    always_comb begin
        bin = gray2bin(sync_q[SYNC_STAGES-1]);
        chg = (bin != data_q);
        inc = (bin == W'(data_q + W'(1)));
    end

    // Clear wins over capture; an error detected this cycle wins over err_clr_i.
    always_comb begin
        sync_d = sync_q;
        data_d = data_q;
        step_d = step_q;
        err_d  = err_q;
        if (cke_i) begin
            if (rst_i) begin
                sync_d = '0;
                data_d = '0;
                step_d = 1'b0;
                err_d  = 1'b0;
            end else begin
                sync_d = {sync_q[SYNC_STAGES-2:0], gray_i};
                step_d = en_i && chg && inc;
                if (en_i) begin
                    data_d = bin;
                end
                err_d = (en_i && chg && !inc) || (err_q && !err_clr_i);
            end
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            sync_q <= '0;
            data_q <= '0;
            step_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            sync_q <= sync_d;
            data_q <= data_d;
            step_q <= step_d;
            err_q  <= err_d;
        end
    end

    assign gray_o = sync_q[SYNC_STAGES-1];
    assign data_o = data_q;
    assign step_o = step_q;
    assign err_o  = err_q;

endmodule

// File: tb/tb_iob_gray_sync_decoder.sv
// Directed bench for iob_gray_sync_decoder: a W=4/2-stage instance and a W=1/3-stage instance,
// with expectations queued at stimulus time and checked when their cycle arrives.
`timescale 1ns/1ps

module tb_iob_gray_sync_decoder;

    logic       clk = 1'b0;
    logic       cke, arst, rst, en, clr_a, clr_b;
    logic [3:0] g_a;
    logic       g_b;
    logic [3:0] gray_a, data_a;
    logic       step_a, err_a;
    logic       gray_b, data_b, step_b, err_b;

    int total = 0;
    int bad   = 0;
    int n     = 0;

    typedef struct {
        int         at;
        int         inst;
        string      tag;
        logic [3:0] g;
        logic [3:0] d;
        logic       s;
        logic       e;
    } exp_t;

    exp_t sb[$];

    iob_gray_sync_decoder #(.W(4), .SYNC_STAGES(2)) dut_a (
        .clk_i(clk), .cke_i(cke), .arst_i(arst), .rst_i(rst), .en_i(en),
        .gray_i(g_a), .err_clr_i(clr_a),
        .gray_o(gray_a), .data_o(data_a), .step_o(step_a), .err_o(err_a)
    );

    iob_gray_sync_decoder #(.W(1), .SYNC_STAGES(3)) dut_b (
        .clk_i(clk), .cke_i(cke), .arst_i(arst), .rst_i(rst), .en_i(en),
        .gray_i(g_b), .err_clr_i(clr_b),
        .gray_o(gray_b), .data_o(data_b), .step_o(step_b), .err_o(err_b)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] g4(input int k);
        return 4'(k ^ (k >> 1));
    endfunction

    task automatic push(input int inst, input int lat, input string tag,
                        input logic [3:0] g, input logic [3:0] d, input logic s, input logic e);
        exp_t x;
        int   i;
        x.at = n + lat; x.inst = inst; x.tag = tag;
        x.g = g; x.d = d; x.s = s; x.e = e;
        i = 0;
        while (i < sb.size() && sb[i].at <= x.at) i++;
        sb.insert(i, x);
    endtask

    task automatic cmp(input string tag, input string fld, input logic [3:0] o, input logic [3:0] x);
        total++;
        assert (o === x) else begin
            bad++;
            $error("FAIL %s %s: got %h expected %h (cycle %0d)", tag, fld, o, x, n);
        end
    endtask

    task automatic settle();
        exp_t       x;
        logic [3:0] og, od;
        logic       os, oe;
        while (sb.size() > 0 && sb[0].at <= n) begin
            x = sb.pop_front();
            if (x.inst == 0) begin
                og = gray_a; od = data_a; os = step_a; oe = err_a;
            end else begin
                og = {3'b000, gray_b}; od = {3'b000, data_b}; os = step_b; oe = err_b;
            end
            cmp(x.tag, "gray_o", og, x.g);
            cmp(x.tag, "data_o", od, x.d);
            cmp(x.tag, "step_o", {3'b000, os}, {3'b000, x.s});
            cmp(x.tag, "err_o",  {3'b000, oe}, {3'b000, x.e});
        end
    endtask

    task automatic cyc(input int k = 1);
        repeat (k) begin
            @(posedge clk);
            #1;
            n++;
            settle();
        end
    endtask

    task automatic goto_a(input int k);
        rst = 1'b1; g_a = 4'h0;
        cyc();
        rst = 1'b0;
        cyc(3);
        for (int j = 1; j <= k; j++) begin
            g_a = g4(j);
            cyc(4);
        end
    endtask

    initial begin
        cke = 1'b1; arst = 1'b0; rst = 1'b0; en = 1'b1;
        clr_a = 1'b0; clr_b = 1'b0; g_a = 4'h0; g_b = 1'b0;
        #2 arst = 1'b1;
        #1;
        push(0, 0, "arst_a", 4'h0, 4'h0, 1'b0, 1'b0);
        push(1, 0, "arst_b", 4'h0, 4'h0, 1'b0, 1'b0);
        settle();
        cyc(2);
        arst = 1'b0;
        push(0, 3, "idle_a", 4'h0, 4'h0, 1'b0, 1'b0);
        cyc(4);

        // Full gray count with wrap; each value held four cycles
        for (int k = 0; k <= 16; k++) begin
            g_a = g4(k % 16);
            push(0, 2, "seq_pre",  g4(k % 16), 4'((k == 0) ? 0 : (k - 1) % 16), 1'b0, 1'b0);
            push(0, 3, "seq_upd",  g4(k % 16), 4'(k % 16), (k != 0), 1'b0);
            cyc(4);
        end

        // Illegal jump 5 -> 8, then clear, then clear colliding with a new error
        for (int j = 1; j <= 5; j++) begin
            g_a = g4(j);
            cyc(4);
        end
        g_a = 4'b1100;
        push(0, 2, "jump_pre",   4'hC, 4'h5, 1'b0, 1'b0);
        push(0, 3, "jump_err",   4'hC, 4'h8, 1'b0, 1'b1);
        push(0, 6, "jump_stick", 4'hC, 4'h8, 1'b0, 1'b1);
        cyc(6);
        clr_a = 1'b1;
        push(0, 1, "err_clr", 4'hC, 4'h8, 1'b0, 1'b0);
        cyc();
        clr_a = 1'b0;
        cyc();
        g_a = 4'b1010;
        cyc(2);
        clr_a = 1'b1;
        push(0, 1, "clr_vs_set", 4'hA, 4'hC, 1'b0, 1'b1);
        cyc();
        clr_a = 1'b0;
        cyc();

        // en_i low across a single legal step, then cke_i low stretches the pulse
        goto_a(2);
        en = 1'b0; g_a = g4(3);
        push(0, 3, "en_hold3", 4'h2, 4'h2, 1'b0, 1'b0);
        push(0, 4, "en_hold4", 4'h2, 4'h2, 1'b0, 1'b0);
        cyc(5);
        en = 1'b1;
        push(0, 1, "en_step", 4'h2, 4'h3, 1'b1, 1'b0);
        cyc();
        cke = 1'b0;
        push(0, 2, "cke_stretch", 4'h2, 4'h3, 1'b1, 1'b0);
        cyc(2);
        cke = 1'b1;
        push(0, 1, "cke_resume", 4'h2, 4'h3, 1'b0, 1'b0);
        cyc();

        // en_i low across two increments reads as an illegal jump
        goto_a(2);
        en = 1'b0; g_a = g4(4);
        push(0, 4, "en2_hold", 4'h6, 4'h2, 1'b0, 1'b0);
        cyc(5);
        en = 1'b1;
        push(0, 1, "en2_jump", 4'h6, 4'h4, 1'b0, 1'b1);
        cyc(2);

        // Synchronous clear mid-stream with gray_i left at 1101
        goto_a(9);
        rst = 1'b1;
        push(0, 1, "rst_clear", 4'h0, 4'h0, 1'b0, 1'b0);
        cyc();
        rst = 1'b0;
        push(0, 2, "rst_sync", 4'hD, 4'h0, 1'b0, 1'b0);
        push(0, 3, "rst_jump", 4'hD, 4'h9, 1'b0, 1'b1);
        cyc(4);

        // W=1, three sync stages: both toggles are legal steps
        g_b = 1'b1;
        push(1, 3, "b_rise_sync", 4'h1, 4'h0, 1'b0, 1'b0);
        push(1, 4, "b_rise_upd",  4'h1, 4'h1, 1'b1, 1'b0);
        push(1, 5, "b_rise_end",  4'h1, 4'h1, 1'b0, 1'b0);
        cyc(6);
        g_b = 1'b0;
        push(1, 3, "b_fall_sync", 4'h0, 4'h1, 1'b0, 1'b0);
        push(1, 4, "b_fall_upd",  4'h0, 4'h0, 1'b1, 1'b0);
        push(1, 5, "b_fall_end",  4'h0, 4'h0, 1'b0, 1'b0);
        cyc(6);

        while (sb.size() > 0) begin
            exp_t x;
            x = sb.pop_front();
            total++;
            bad++;
            $display("FAIL %s: check never reached (due cycle %0d, now %0d)", x.tag, x.at, n);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
